uart_cmd_engine: RTL and testbench
==================================

// Module: uart_cmd_engine
// PURPOSE
//  Host-side command engine at the FIFO end of the UART block: pops RX FIFO bytes, parses
//  register read/write frames, drives a simple register bus, pushes response bytes to TX FIFO.
//  Sits between the uart instance and the design's control/status registers in the top module.
// PARAMETERS
//  ADDR_WIDTH      8        register address width (frame carries one addr byte, zero-extended)
//  READ_LATENCY    1        clocks from reg_re pulse to reg_rdata valid (1..4)
//  TIMEOUT_CYCLES  270000   max idle clocks between bytes of one frame (10 ms @ 27 MHz)
// PORTS
//  clock             in   1   system clock
//  reset             in   1   synchronous, active-high reset
//  rx_fifo_empty     in   1   RX FIFO empty; rx_fifo_data_out valid when low (show-ahead)
//  rx_fifo_data_out  in   8   RX FIFO head byte
//  rx_fifo_read_en   out  1   one-cycle pop of RX FIFO head
//  tx_fifo_full      in   1   TX FIFO full; tie 0 if unavailable
//  tx_fifo_data_in   out  8   response byte
//  tx_fifo_write_en  out  1   one-cycle push of tx_fifo_data_in
//  reg_addr          out  ADDR_WIDTH  register address, stable from strobe through response
//  reg_wdata         out  8   write data, valid with reg_we
//  reg_we            out  1   one-cycle write strobe
//  reg_re            out  1   one-cycle read strobe
//  reg_rdata         in   8   read data, sampled READ_LATENCY clocks after reg_re
//  busy              out  1   high in any state other than IDLE
//  err_count         out  8   saturating count of E/T/C responses
// BEHAVIOUR
//  Reset: all outputs 0, FSM -> IDLE, timeout counter 0, checksum accumulator 0.
//  Reset mid-frame abandons the frame; already-popped bytes are lost, no response sent.
//  Pop rule: rx_fifo_read_en only when rx_fifo_empty=0 and no pop in previous cycle
//   (FIFO flags update one clock after a pop); byte consumed = rx_fifo_data_out that cycle.
//  Frames: 'W'(0x57) addr data -> reg_we, reply 'K'(0x4B);
//   'R'(0x52) addr -> reg_re, reply reg_rdata byte;
//   any other first byte -> discard, reply 'E'(0x45), FSM stays IDLE.
//  FSM: IDLE -(pop W/R)-> GET_ADDR -(pop; R)-> EXEC_RD, (pop; W)-> GET_DATA -(pop)-> EXEC_WR
//   EXEC_WR: reg_we=1 one clock -> RESP(0x4B)
//   EXEC_RD: reg_re=1 one clock -> WAIT_RD, READ_LATENCY clocks, latch reg_rdata -> RESP
//   RESP: push when tx_fifo_full=0 (stall while full), one pulse -> IDLE.
//  Latency: last byte popped -> reg_we at +1 clock -> tx push at +2 clocks (TX not full).
//   Read: last pop -> reg_re +1 -> tx push at +2+READ_LATENCY.
//  Timeout: counter clears on every pop, counts in GET_* states; at TIMEOUT_CYCLES-1 with
//   FIFO still empty -> RESP with 'T'(0x54), no register access. Pop and expiry same
//   cycle: pop wins.
//  Never more than one response in flight; RX popping halted from EXEC_* until RESP pushes.
//  err_count increments on each E/T/C push, saturates at 0xFF, no wrap.
//  reg_addr/reg_wdata hold last values in IDLE; reg_we and reg_re never high together.
// CONFIGURATION
//  CMD_CHECKSUM_EN defined: frames carry a trailing byte = XOR of all prior frame bytes;
//   extra state GET_CSUM after GET_ADDR (R) / GET_DATA (W); mismatch -> reply 'C'(0x43),
//   no strobe; timeout also covers GET_CSUM. Latencies above count from checksum pop.
//  Undefined: no checksum byte, GET_CSUM absent, 'C' never produced.
// TESTING
//  W 0x10 0x5A -> one reg_we, addr=0x10, wdata=0x5A; tx 0x4B; err_count 0.
//  reg_rdata=0xC3 at addr 0x22, R 0x22 -> one reg_re, tx 0xC3 READ_LATENCY+2 clocks after pop.
//  0x41 then W 0x01 0x02 -> tx 0x45 then 0x4B; err_count 1; single reg_we.
//  'W' 0x10 then silence TIMEOUT_CYCLES -> tx 0x54, no reg_we; next valid frame works.
//  tx_fifo_full=1 during RESP for 50 clocks -> no push, no pops; push 1 clock after release.
//  CMD_CHECKSUM_EN: W 0x10 0x5A 0x1D -> 0x4B; W 0x10 0x5A 0x00 -> 0x43, no reg_we.
//  Reset asserted after 'W' 0x10 -> outputs 0, no response; following R frame answered.

Source files
------------

// File: rtl/uart_cmd_engine.sv
// Command engine: pops RX FIFO bytes, parses 'W'/'R' register frames, drives the register bus
// and pushes one response byte per frame. Define CMD_CHECKSUM_EN for a trailing XOR check byte.
module uart_cmd_engine #(
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_fifo_empty,
    input  logic [7:0]            rx_fifo_data_out,
    output logic                  rx_fifo_read_en,
    input  logic                  tx_fifo_full,
    output logic [7:0]            tx_fifo_data_in,
    output logic                  tx_fifo_write_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;
    localparam logic [7:0] RSP_E  = 8'h45;
    localparam logic [7:0] RSP_T  = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
`ifdef CMD_CHECKSUM_EN
        S_GET_CSUM,
`endif
        S_EXEC_WR,
        S_EXEC_RD,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            resp_q, resp_d;
    logic                  resp_err_q, resp_err_d;
    logic                  is_wr_q, is_wr_d;
    logic [1:0]            wait_q, wait_d;
    logic [7:0]            err_q, err_d;
    logic                  pop_q;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic rx_phase;
    logic get_phase;
    logic pop;
    logic push;
    logic tmo_expired;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        resp_err_d = resp_err_q;
        is_wr_d    = is_wr_q;
        wait_d     = wait_q;
        err_d      = err_q;
`ifdef CMD_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        rx_phase = (state_q == S_IDLE) || (state_q == S_GET_ADDR) || (state_q == S_GET_DATA)
`ifdef CMD_CHECKSUM_EN
                   || (state_q == S_GET_CSUM)
`endif
                   ;
        get_phase   = rx_phase && (state_q != S_IDLE);
        // FIFO flags lag a pop by one clock, so never pop on consecutive cycles.
        pop         = rx_phase && !rx_fifo_empty && !pop_q;
        push        = (state_q == S_RESP) && !tx_fifo_full;
        tmo_expired = get_phase && (tmo_q == TMO_LAST);
        tmo_d       = (pop || !get_phase) ? '0 : tmo_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
`ifdef CMD_CHECKSUM_EN
                    csum_d = rx_fifo_data_out;
`endif
                    if (rx_fifo_data_out == CMD_WR || rx_fifo_data_out == CMD_RD) begin
                        is_wr_d = (rx_fifo_data_out == CMD_WR);
                        state_d = S_GET_ADDR;
                    end else begin
                        resp_d     = RSP_E;
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
            S_GET_ADDR: begin
                if (pop) begin
                    addr_d = ADDR_WIDTH'(rx_fifo_data_out);
`ifdef CMD_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_fifo_data_out;
                    state_d = is_wr_q ? S_GET_DATA : S_GET_CSUM;
`else
                    state_d = is_wr_q ? S_GET_DATA : S_EXEC_RD;
`endif
                end
            end
            S_GET_DATA: begin
                if (pop) begin
                    wdata_d = rx_fifo_data_out;
`ifdef CMD_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_fifo_data_out;
                    state_d = S_GET_CSUM;
`else
                    state_d = S_EXEC_WR;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            S_GET_CSUM: begin
                if (pop) begin
                    if (rx_fifo_data_out == csum_q) begin
                        state_d = is_wr_q ? S_EXEC_WR : S_EXEC_RD;
                    end else begin
                        resp_d     = 8'h43;
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
`endif
            S_EXEC_WR: begin
                resp_d     = RSP_OK;
                resp_err_d = 1'b0;
                state_d    = S_RESP;
            end
            S_EXEC_RD: begin
                wait_d  = '0;
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (wait_q == WAIT_LAST) begin
                    resp_d     = reg_rdata;
                    resp_err_d = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RESP: begin
                if (push) begin
                    state_d = S_IDLE;
                    if (resp_err_q && err_q != 8'hFF) err_d = err_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop in the expiry cycle is handled above and takes priority.
        if (tmo_expired && !pop) begin
            resp_d     = RSP_T;
            resp_err_d = 1'b1;
            state_d    = S_RESP;
        end

        rx_fifo_read_en  = pop;
        tx_fifo_write_en = push;
        tx_fifo_data_in  = resp_q;
        reg_we           = (state_q == S_EXEC_WR);
        reg_re           = (state_q == S_EXEC_RD);
        reg_addr         = addr_q;
        reg_wdata        = wdata_q;
        busy             = (state_q != S_IDLE);
        err_count        = err_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            resp_err_q <= 1'b0;
            is_wr_q    <= 1'b0;
            wait_q     <= '0;
            err_q      <= '0;
            pop_q      <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            resp_err_q <= resp_err_d;
            is_wr_q    <= is_wr_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            pop_q      <= pop;
`ifdef CMD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine: show-ahead RX FIFO model, TX capture log and a
// register stub with exact read latency; each scenario task checks its own results.
module tb_uart_cmd_engine;

    localparam int LAT = 2;
    localparam int TO  = 40;
`ifdef CMD_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       clock;
    logic       reset;
    logic       rx_fifo_empty;
    logic [7:0] rx_fifo_data_out;
    logic       rx_fifo_read_en;
    logic       tx_fifo_full;
    logic [7:0] tx_fifo_data_in;
    logic       tx_fifo_write_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [7:0] err_count;

    uart_cmd_engine #(
        .ADDR_WIDTH(8), .READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out),
        .rx_fifo_read_en(rx_fifo_read_en),
        .tx_fifo_full(tx_fifo_full), .tx_fifo_data_in(tx_fifo_data_in),
        .tx_fifo_write_en(tx_fifo_write_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // RX FIFO model
    logic [7:0] rx_mem [0:63];
    logic [6:0] wr_ptr = '0;
    logic [6:0] rd_ptr = '0;
    assign rx_fifo_empty    = (wr_ptr == rd_ptr);
    assign rx_fifo_data_out = rx_mem[rd_ptr[5:0]];

    // Register stub and monitors
    logic [7:0] reg_mem [0:255];
    logic [7:0] rd_pipe [0:LAT-1];
    assign reg_rdata = rd_pipe[LAT-1];

    int         cyc = 0;
    int         pop_cnt = 0, last_pop_cyc = 0, bad_pop = 0;
    int         tx_n = 0, bad_push = 0;
    logic [7:0] tx_log [0:511];
    int         tx_cyc [0:511];
    int         we_cnt = 0, re_cnt = 0, both_cnt = 0;
    logic [7:0] we_addr = '0, we_data = '0, re_addr = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rx_fifo_read_en) begin
            if (rx_fifo_empty) bad_pop <= bad_pop + 1;
            rd_ptr       <= rd_ptr + 1'b1;
            pop_cnt      <= pop_cnt + 1;
            last_pop_cyc <= cyc;
        end
        if (tx_fifo_write_en && tx_fifo_full) bad_push <= bad_push + 1;
        if (tx_fifo_write_en && !tx_fifo_full) begin
            tx_log[tx_n] <= tx_fifo_data_in;
            tx_cyc[tx_n] <= cyc;
            tx_n         <= tx_n + 1;
        end
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
        end
        if (reg_re) begin
            re_cnt  <= re_cnt + 1;
            re_addr <= reg_addr;
        end
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
        rd_pipe[0] <= reg_re ? reg_mem[reg_addr] : 8'hEE;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic put_byte(input logic [7:0] b);
        rx_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input bit has_data);
        logic [7:0] cs;
        cs = cmd ^ addr;
        put_byte(cmd);
        put_byte(addr);
        if (has_data) begin
            put_byte(data);
            cs = cs ^ data;
        end
        if (CS != 0) put_byte(cs);
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (tx_n < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (tx_n < n) begin
            errors++;
            $display("FAIL %s_wait: responses %0d, required %0d within %0d cycles",
                     name, tx_n, n, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_fifo_full = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({rx_fifo_read_en, tx_fifo_write_en, reg_we, reg_re, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {rx_fifo_read_en, tx_fifo_write_en, reg_we, reg_re, busy});
        end
        checks++;
        if ({tx_fifo_data_in, reg_addr, reg_wdata, err_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: got %h required 00000000",
                     {tx_fifo_data_in, reg_addr, reg_wdata, err_count});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_write();
        int b;
        b = tx_n;
        send_frame(8'h57, 8'h10, 8'h5A, 1'b1);
        wait_tx(b + 1, 100, "write");
        @(negedge clock);
        checks++;
        if (tx_log[b] !== 8'h4B) begin
            errors++; $display("FAIL write_resp: got %h required 4b", tx_log[b]);
        end
        checks++;
        if (we_cnt !== 1 || we_addr !== 8'h10 || we_data !== 8'h5A) begin
            errors++;
            $display("FAIL write_strobe: cnt %0d addr %h data %h required 1 10 5a",
                     we_cnt, we_addr, we_data);
        end
        checks++;
        if (tx_cyc[b] - last_pop_cyc !== 2) begin
            errors++;
            $display("FAIL write_latency: got %0d required 2", tx_cyc[b] - last_pop_cyc);
        end
        checks++;
        if (err_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_idle: err %0d busy %b required 0 0", err_count, busy);
        end
    endtask

    task automatic test_read();
        int b;
        b = tx_n;
        send_frame(8'h52, 8'h22, 8'h00, 1'b0);
        wait_tx(b + 1, 100, "read");
        checks++;
        if (tx_log[b] !== 8'hC3) begin
            errors++; $display("FAIL read_resp: got %h required c3", tx_log[b]);
        end
        checks++;
        if (re_cnt !== 1 || re_addr !== 8'h22) begin
            errors++;
            $display("FAIL read_strobe: cnt %0d addr %h required 1 22", re_cnt, re_addr);
        end
        checks++;
        if (tx_cyc[b] - last_pop_cyc !== 2 + LAT) begin
            errors++;
            $display("FAIL read_latency: got %0d required %0d", tx_cyc[b] - last_pop_cyc, 2 + LAT);
        end
    endtask

    task automatic test_bad_cmd();
        int b;
        b = tx_n;
        put_byte(8'h41);
        send_frame(8'h57, 8'h01, 8'h02, 1'b1);
        wait_tx(b + 2, 100, "badcmd");
        @(negedge clock);
        checks++;
        if (tx_log[b] !== 8'h45 || tx_log[b+1] !== 8'h4B) begin
            errors++;
            $display("FAIL badcmd_resp: got %h %h required 45 4b", tx_log[b], tx_log[b+1]);
        end
        checks++;
        if (err_count !== 8'd1 || we_cnt !== 2 || we_addr !== 8'h01 || we_data !== 8'h02) begin
            errors++;
            $display("FAIL badcmd_state: err %0d we %0d addr %h data %h required 1 2 01 02",
                     err_count, we_cnt, we_addr, we_data);
        end
    endtask

    task automatic test_timeout();
        int b;
        b = tx_n;
        put_byte(8'h57);
        put_byte(8'h10);
        wait_tx(b + 1, TO + 50, "timeout");
        @(negedge clock);
        checks++;
        if (tx_log[b] !== 8'h54 || tx_cyc[b] - last_pop_cyc !== TO + 1) begin
            errors++;
            $display("FAIL timeout_resp: got %h after %0d required 54 after %0d",
                     tx_log[b], tx_cyc[b] - last_pop_cyc, TO + 1);
        end
        checks++;
        if (we_cnt !== 2 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL timeout_state: we %0d err %0d required 2 2", we_cnt, err_count);
        end
        send_frame(8'h57, 8'h33, 8'h44, 1'b1);
        wait_tx(b + 2, 100, "timeout_next");
        @(negedge clock);
        checks++;
        if (tx_log[b+1] !== 8'h4B || we_cnt !== 3 || we_addr !== 8'h33 || we_data !== 8'h44) begin
            errors++;
            $display("FAIL timeout_next: resp %h we %0d addr %h data %h required 4b 3 33 44",
                     tx_log[b+1], we_cnt, we_addr, we_data);
        end
    endtask

    task automatic test_tx_stall();
        int b, p, rel, k;
        b = tx_n;
        p = pop_cnt;
        tx_fifo_full = 1'b1;
        send_frame(8'h52, 8'h22, 8'h00, 1'b0);
        send_frame(8'h57, 8'h05, 8'h06, 1'b1);
        k = 0;
        while (pop_cnt < p + 2 + CS && k < 50) begin
            @(negedge clock);
            k++;
        end
        repeat (50) @(negedge clock);
        checks++;
        if (tx_n !== b || pop_cnt !== p + 2 + CS || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: tx %0d pops %0d busy %b required %0d %0d 1",
                     tx_n - b, pop_cnt - p, busy, 0, 2 + CS);
        end
        rel = cyc;
        tx_fifo_full = 1'b0;
        wait_tx(b + 2, 100, "stall");
        checks++;
        if (tx_log[b] !== 8'hC3 || tx_cyc[b] !== rel) begin
            errors++;
            $display("FAIL stall_release: got %h at %0d required c3 at %0d", tx_log[b], tx_cyc[b], rel);
        end
        @(negedge clock);
        checks++;
        if (tx_log[b+1] !== 8'h4B || we_addr !== 8'h05 || we_data !== 8'h06) begin
            errors++;
            $display("FAIL stall_next: resp %h addr %h data %h required 4b 05 06",
                     tx_log[b+1], we_addr, we_data);
        end
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_checksum();
        int b, w;
        b = tx_n;
        w = we_cnt;
        put_byte(8'h57); put_byte(8'h10); put_byte(8'h5A); put_byte(8'h1D);
        put_byte(8'h57); put_byte(8'h10); put_byte(8'h5A); put_byte(8'h00);
        wait_tx(b + 2, 200, "csum");
        @(negedge clock);
        checks++;
        if (tx_log[b] !== 8'h4B || tx_log[b+1] !== 8'h43) begin
            errors++;
            $display("FAIL csum_resp: got %h %h required 4b 43", tx_log[b], tx_log[b+1]);
        end
        checks++;
        if (we_cnt !== w + 1 || err_count !== 8'd3) begin
            errors++;
            $display("FAIL csum_state: we %0d err %0d required %0d 3", we_cnt, err_count, w + 1);
        end
    endtask
`endif

    task automatic test_reset_midframe();
        int b, p, k;
        b = tx_n;
        p = pop_cnt;
        put_byte(8'h57);
        put_byte(8'h10);
        k = 0;
        while (pop_cnt < p + 2 && k < 50) begin
            @(negedge clock);
            k++;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, reg_we, reg_re, tx_fifo_write_en, rx_fifo_read_en} !== 5'b0 ||
            {reg_addr, err_count} !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs: flags %b addr %h err %h required 00000 00 00",
                     {busy, reg_we, reg_re, tx_fifo_write_en, rx_fifo_read_en}, reg_addr, err_count);
        end
        reset = 1'b0;
        repeat (TO + 20) @(negedge clock);
        checks++;
        if (tx_n !== b || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_silent: responses %0d busy %b required 0 0", tx_n - b, busy);
        end
        send_frame(8'h52, 8'h22, 8'h00, 1'b0);
        wait_tx(b + 1, 100, "midreset_read");
        checks++;
        if (tx_log[b] !== 8'hC3) begin
            errors++; $display("FAIL midreset_read: got %h required c3", tx_log[b]);
        end
    endtask

    task automatic test_err_saturate();
        int b;
        b = tx_n;
        for (int batch = 0; batch < 13; batch++) begin
            for (int i = 0; i < 20; i++) put_byte(8'h41);
            wait_tx(b + 20 * (batch + 1), 200, "sat");
        end
        @(negedge clock);
        checks++;
        if (err_count !== 8'hFF || tx_log[tx_n-1] !== 8'h45) begin
            errors++;
            $display("FAIL err_saturate: err %h last %h required ff 45", err_count, tx_log[tx_n-1]);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (both_cnt !== 0 || bad_pop !== 0 || bad_push !== 0) begin
            errors++;
            $display("FAIL invariants: we&re %0d empty_pops %0d full_pushes %0d required 0 0 0",
                     both_cnt, bad_pop, bad_push);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) reg_mem[i] = 8'(i);
        reg_mem[8'h22] = 8'hC3;
        reset = 1'b1;
        tx_fifo_full = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_tx_stall();
`ifdef CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midframe();
        test_err_saturate();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
